// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, oversampling ratio and default payload width.
// Used by uart_tx and uart_baud_gen.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int OVERSAMPLE         = 8;
  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period generator: emits a one-cycle tick every OVERSAMPLE * max(prescale, 1) cycles.
// The prescale value is captured on start, so mid-frame changes have no effect.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      run,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  // Wide enough that OVERSAMPLE * prescale can never overflow.
  localparam int CW = PRESCALE_WIDTH + 3;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] period_q;
  logic [CW-1:0] period_d;

  always_comb begin
    period_d = CW'(prescale) * CW'(OVERSAMPLE);
    if (prescale == '0) period_d = CW'(OVERSAMPLE);
  end

  assign tick = run && (cnt_q == period_q - 1'b1);

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else if (start) begin
      cnt_q    <= '0;
      period_q <= period_d;
    end else if (run) begin
      cnt_q <= tick ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: LSB-first 8N1 framing on txd from an AXI-stream style byte input.
// Defining UART_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      txd,
  output logic                      busy
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  txd_q, txd_d;
  logic                  handshake;
  logic                  tick;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  assign s_axis_tready = (state_q == IDLE) && !rst;
  assign handshake     = s_axis_tvalid && s_axis_tready;
  assign busy          = (state_q != IDLE);
  assign txd           = txd_q;

  uart_baud_gen #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_baud_gen (
    .clk     (clk),
    .rst     (rst),
    .start   (handshake),
    .run     (busy),
    .prescale(prescale),
    .tick    (tick)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    txd_d     = txd_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (handshake) begin
          state_d   = START;
          shift_d   = s_axis_tdata;
          bit_cnt_d = '0;
          txd_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
          parity_d  = ^s_axis_tdata;
`endif
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = parity_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            txd_d     = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        txd_d   = 1'b1;
      end
    endcase
  end

  // Reset forces the line idle-high immediately and drops any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      txd_q     <= txd_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: the driver queues expected frames, and a monitor decodes txd against them.
// Honours UART_TX_PARITY_EN for the frame length and the parity bit.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [15:0] prescale = 16'd1;
  logic        txd;
  logic        busy;

  uart_tx #(
    .DATA_WIDTH    (8),
    .PRESCALE_WIDTH(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .prescale     (prescale),
    .txd          (txd),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         pe;
    int         hs;
  } exp_t;

  exp_t exp_q[$];
  int   cyc    = 0;
  int   total  = 0;
  int   bad    = 0;
  bit   mon_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Offer a byte; return the handshake cycle. Returns at the falling edge just after the handshake.
  task automatic send(input logic [7:0] d, input logic [15:0] p, input bit push, input bit hold,
                      output int hs);
    int waited = 0;
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    prescale      = p;
    while (!s_axis_tready && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    check("handshake_wait", waited < 4000, 1);
    hs = cyc + 1;
    if (push) exp_q.push_back('{data: d, pe: (p == 0) ? 1 : int'(p), hs: hs});
    @(negedge clk);
    if (!hold) s_axis_tvalid = 1'b0;
  endtask

  // busy/tready across one whole frame starting at handshake cycle hs.
  task automatic watch_frame(input int pe);
    bit ok = 1'b1;
    for (int i = 0; i < NB * 8 * pe; i++) begin
      if (!(busy === 1'b1 && s_axis_tready === 1'b0)) ok = 1'b0;
      @(negedge clk);
    end
    check("busy_during_frame", ok, 1);
    check("busy_after_frame", busy, 0);
    check("tready_after_frame", s_axis_tready, 1);
    check("txd_idle_after_frame", txd, 1);
  endtask

  // Monitor: decode each frame from txd and compare with the next queued expectation.
  initial begin
    exp_t        it;
    logic        lv[NB];
    logic [7:0]  got;
    bit          ok;
    forever begin
      @(negedge clk);
      if (mon_en && !rst && txd === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 1, 0);
          while (txd === 1'b0) @(negedge clk);
        end else begin
          it = exp_q.pop_front();
          check("start_cycle", cyc, it.hs);
          lv[0] = 1'b0;
          for (int k = 0; k < 8; k++) lv[k+1] = it.data[k];
`ifdef UART_TX_PARITY_EN
          lv[9] = ^it.data;
`endif
          lv[NB-1] = 1'b1;
          got = '0;
          for (int j = 0; j < NB; j++) begin
            ok = 1'b1;
            for (int c = 0; c < 8 * it.pe; c++) begin
              if (!(j == 0 && c == 0)) @(negedge clk);
              if (txd !== lv[j]) ok = 1'b0;
              if (j >= 1 && j <= 8 && c == 4 * it.pe) got[j-1] = txd;
            end
            check($sformatf("bit%0d_level_data%02h", j, it.data), ok, 1);
          end
          check("decoded_byte", got, it.data);
        end
      end
    end
  end

  initial begin
    int hs, hs2, waited;
    logic [7:0] d;
    logic [15:0] p;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_tready", s_axis_tready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("tready_after_release", s_axis_tready, 1);

    // P=1, 0x55
    send(8'h55, 16'd1, 1, 0, hs);
    watch_frame(1);

    // P=2 back-to-back with tvalid held high
    send(8'hA3, 16'd2, 1, 1, hs);
    send(8'h0F, 16'd2, 1, 0, hs2);
    check("b2b_spacing", hs2 - hs, NB * 16 + 1);
    watch_frame(2);

    // P=0 behaves like P=1
    send(8'hFF, 16'd0, 1, 0, hs);
    watch_frame(1);

    // Reset mid-frame discards the byte
    mon_en = 1'b0;
    send(8'h3C, 16'd1, 0, 0, hs);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_txd", txd, 1);
    check("abort_busy", busy, 0);
    check("abort_tready", s_axis_tready, 0);
    repeat (2) @(negedge clk);
    check("abort_tready_held", s_axis_tready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_tready_release", s_axis_tready, 1);
    check("abort_idle_txd", txd, 1);
    mon_en = 1'b1;
    send(8'h81, 16'd1, 1, 0, hs);
    watch_frame(1);

    // Prescale change mid-frame only affects the next frame
    send(8'h96, 16'd1, 1, 0, hs);
    fork
      watch_frame(1);
      begin
        repeat (19) @(negedge clk);
        prescale = 16'd4;
      end
    join
    send(8'h4B, 16'd4, 1, 0, hs);
    watch_frame(4);

    // Parity corner byte (odd popcount)
    send(8'h07, 16'd1, 1, 0, hs);
    watch_frame(1);

    // Randomized bytes and prescales
    for (int n = 0; n < 8; n++) begin
      d = 8'($urandom);
      p = 16'($urandom_range(0, 3));
      send(d, p, 1, 0, hs);
      watch_frame((p == 0) ? 1 : int'(p));
    end

    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
